wishbone_fifo_target: RTL and testbench
=======================================

# wishbone_fifo_target

Wishbone B4 classic target that terminates single read/write cycles into an internal FIFO. Writes push `dat_i`; reads pop the oldest entry onto `dat_o`. It sits directly downstream of the team's classic cycle controller and gives that controller a buffered data sink/source. When the FIFO cannot service an access, the target inserts wait states by withholding `ack_o`.

## Interface
- `DAT_WIDTH`, default 8: data width in bits.
- `DEPTH`, default 4: FIFO entries; must be a power of two and at least 2.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `cyc_i`  in  1  Wishbone cycle valid.
- `stb_i`  in  1  Wishbone strobe.
- `we_i`  in  1  1 = write (push), 0 = read (pop).
- `dat_i`  in  `DAT_WIDTH`  write data.
- `dat_o`  out  `DAT_WIDTH`  read data; registered.
- `ack_o`  out  1  cycle termination; registered, single-cycle pulse.
- `err_o`  out  1  error termination; present only with `WB_FIFO_TARGET_ERR_EN`.
- `count_o`  out  `$clog2(DEPTH)+1`  current occupancy, 0..`DEPTH`.
- `full_o`  out  1  `count_o == DEPTH`.
- `empty_o`  out  1  `count_o == 0`.

## Operation
- Two-state FSM:
  - IDLE: `ack_o` = 0.
  - TERM: `ack_o` = 1 (or `err_o` = 1) for exactly one cycle, then unconditional return to IDLE.
- Access request: `req = cyc_i && stb_i`. It is sampled only in IDLE, so a strobe held high through `ack_o` is never double-accepted.
- IDLE, `req && we_i && !full_o`: write `dat_i` at the write pointer, advance the pointer, increment count, go to TERM.
- IDLE, `req && !we_i && !empty_o`: load `dat_o` from the read pointer, advance the pointer, decrement count, go to TERM.
- IDLE, request to a full FIFO (write) or an empty FIFO (read): stay in IDLE with `ack_o` = 0 (wait state). FIFO state is unchanged. Re-evaluated every cycle.
- Pointers are `$clog2(DEPTH)` bits and wrap from `DEPTH-1` to 0 naturally.
- Only one push or one pop per accepted access. Simultaneous push and pop cannot occur.
- `dat_o` holds its last popped value until the next pop. It is not cleared after the cycle.
- `cyc_i` or `stb_i` dropped during wait states: the request is abandoned and nothing is committed.
- `cyc_i` or `stb_i` dropped while in TERM: the transfer is already committed and `ack_o` still completes its pulse.
- Reset, including mid-cycle: pointers = 0, count = 0, FSM = IDLE, `ack_o` = 0, `err_o` = 0, `dat_o` = 0, `empty_o` = 1, `full_o` = 0. FIFO contents are undefined and never exposed.

## Timing
- Latency: request sampled at edge N with space or data available → `ack_o` high from edge N to edge N+1.
- Read data is valid on `dat_o` in the same cycle `ack_o` is high.
- `count_o`, `full_o` and `empty_o` update at edge N, concurrently with `ack_o` rising.
- With `stb_i` held continuously, the target completes one transfer every 2 cycles.
- `full_o` and `empty_o` are combinational decodes of the registered count. There is no combinational path from any input to any output.

## Configuration
- `WB_FIFO_TARGET_ERR_EN` defined:
  - `err_o` port exists.
  - A write to a full FIFO or a read from an empty FIFO goes to TERM with `err_o` = 1 and `ack_o` = 0 for one cycle, with no FIFO change and `dat_o` unchanged.
  - Latency is the same as for a normal access.
- Not defined:
  - `err_o` is absent.
  - Such accesses wait indefinitely, as described under Operation.

## Test plan
- Reset then read, macro off: release `rst_ni` and hold a read strobe for 5 cycles → `ack_o` stays 0 and `empty_o` = 1. Then write 0xA5 → `ack_o` pulses 1 cycle after the write is sampled. The pending read then acks with `dat_o` = 0xA5 and `count_o` = 0.
- Fill and drain, `DEPTH` = 4: write 0x11, 0x22, 0x33, 0x44 → `full_o` = 1 and `count_o` = 4. A fifth write waits. Read 4 times → 0x11, 0x22, 0x33, 0x44 in order, then `empty_o` = 1.
- Wrap-around: run 3 write/read pairs, then 4 writes 0x01 to 0x04 and 4 reads → data returns in order across the pointer wrap, with `count_o` back to 0.
- Back-to-back strobe: hold `stb_i` high for 8 cycles with `we_i` = 1 and an empty FIFO → exactly 4 `ack_o` pulses on alternate cycles and `count_o` = 4.
- Async reset mid-operation: assert `rst_ni` low between edges while `ack_o` = 1 with `count_o` = 2 → `ack_o`, `count_o` and `dat_o` go to 0 immediately, without waiting for a clock edge.
- Macro on: read an empty FIFO → `err_o` pulses 1 cycle, `ack_o` stays 0, `count_o` = 0. Write to a full FIFO → `err_o` pulses and the contents are unchanged on drain.

Source files
------------

// File: rtl/wishbone_fifo_target.sv
// Wishbone B4 classic target: single writes push into a FIFO, single reads pop from it.
// Optional macro WB_FIFO_TARGET_ERR_EN terminates full-write/empty-read with err_o instead of waiting.
module wishbone_fifo_target #(
  parameter int DAT_WIDTH = 8,
  parameter int DEPTH     = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cyc_i,
  input  logic                   stb_i,
  input  logic                   we_i,
  input  logic [DAT_WIDTH-1:0]   dat_i,
  output logic [DAT_WIDTH-1:0]   dat_o,
  output logic                   ack_o,
`ifdef WB_FIFO_TARGET_ERR_EN
  output logic                   err_o,
`endif
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, TERM} state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;
  logic [DAT_WIDTH-1:0] mem_q [DEPTH];

  logic req, push, pop, accept;

  assign req     = cyc_i && stb_i;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  // Requests are only looked at in IDLE, so a strobe held through ack is never taken twice.
  assign push    = (state_q == IDLE) && req && we_i && !full_o;
  assign pop     = (state_q == IDLE) && req && !we_i && !empty_o;

`ifdef WB_FIFO_TARGET_ERR_EN
  logic bad, err_q, err_d;
  assign bad    = (state_q == IDLE) && req && (we_i ? full_o : empty_o);
  assign accept = push || pop || bad;
  assign err_d  = bad;
`else
  assign accept = push || pop;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dat_q   <= '0;
`ifdef WB_FIFO_TARGET_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dat_q   <= dat_d;
`ifdef WB_FIFO_TARGET_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Storage has no reset; its contents only reach dat_o through a pop of a written entry.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= dat_i;
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dat_d   = dat_q;
    case (state_q)
      IDLE:    if (accept) state_d = TERM;
      TERM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (push) begin
      wptr_d  = wptr_q + AW'(1);
      count_d = count_q + CW'(1);
    end
    if (pop) begin
      rptr_d  = rptr_q + AW'(1);
      count_d = count_q - CW'(1);
      dat_d   = mem_q[rptr_q];
    end
  end

  always_comb begin
    dat_o   = dat_q;
    count_o = count_q;
`ifdef WB_FIFO_TARGET_ERR_EN
    ack_o   = (state_q == TERM) && !err_q;
    err_o   = (state_q == TERM) && err_q;
`else
    ack_o   = (state_q == TERM);
`endif
  end
endmodule

// File: tb/tb_wishbone_fifo_target.sv
// Directed bench for wishbone_fifo_target: vector table plus hand sequences for multi-cycle corners.
module tb_wishbone_fifo_target;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int CW = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [DW-1:0] dat_i = '0;
  logic [DW-1:0] dat_o;
  logic          ack_o;
  logic [CW-1:0] count_o;
  logic          full_o, empty_o;
`ifdef WB_FIFO_TARGET_ERR_EN
  logic          err_o;
`endif

  int checks = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  wishbone_fifo_target #(.DAT_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
`ifdef WB_FIFO_TARGET_ERR_EN
    .err_o(err_o),
`endif
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  typedef struct {
    logic          cyc, stb, we;
    logic [DW-1:0] dat;
    logic          ack;
    logic [DW-1:0] dato;
    logic [CW-1:0] cnt;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(logic c, logic s, logic w, logic [DW-1:0] d,
                              logic a, logic [DW-1:0] q, logic [CW-1:0] n);
    vec_t v;
    v.cyc = c; v.stb = s; v.we = w; v.dat = d; v.ack = a; v.dato = q; v.cnt = n;
    vecs.push_back(v);
  endfunction

  // One accepted write followed by an idle cycle.
  function automatic void wr(logic [DW-1:0] d, logic [CW-1:0] n, logic [DW-1:0] held);
    add(1, 1, 1, d, 1, held, n);
    add(0, 0, 0, 8'h00, 0, held, n);
  endfunction

  function automatic void rd(logic [DW-1:0] q, logic [CW-1:0] n);
    add(1, 1, 0, 8'h00, 1, q, n);
    add(0, 0, 0, 8'h00, 0, q, n);
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(logic c, logic s, logic w, logic [DW-1:0] d);
    cyc_i = c; stb_i = s; we_i = w; dat_i = d;
  endtask

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic access(logic c, logic s, logic w, logic [DW-1:0] d);
    drive(c, s, w, d);
    cycle();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive(0, 0, 0, 8'h00);
    cycle();
    cycle();
    chk("rst_ack", 0, 32'(ack_o), 32'd0);
    chk("rst_count", 0, 32'(count_o), 32'd0);
    chk("rst_dat", 0, 32'(dat_o), 32'd0);
    chk("rst_empty", 0, 32'(empty_o), 32'd1);
    chk("rst_full", 0, 32'(full_o), 32'd0);
    rst_ni = 1'b1;
    $display("reset released");
  endtask

  initial begin
    int acks;

    add(0, 0, 0, 8'h00, 0, 8'h00, 0);
    wr(8'h11, 1, 8'h00); wr(8'h22, 2, 8'h00); wr(8'h33, 3, 8'h00); wr(8'h44, 4, 8'h00);
    add(1, 1, 1, 8'h55, 0, 8'h00, 4);
    add(1, 1, 1, 8'h55, 0, 8'h00, 4);
    rd(8'h11, 3); rd(8'h22, 2); rd(8'h33, 1); rd(8'h44, 0);
    add(1, 1, 0, 8'h00, 0, 8'h44, 0);
    add(0, 1, 1, 8'h99, 0, 8'h44, 0);
    add(1, 0, 1, 8'h99, 0, 8'h44, 0);
    wr(8'hA1, 1, 8'h44); rd(8'hA1, 0);
    wr(8'hA2, 1, 8'hA1); rd(8'hA2, 0);
    wr(8'hA3, 1, 8'hA2); rd(8'hA3, 0);
    wr(8'h01, 1, 8'hA3); wr(8'h02, 2, 8'hA3); wr(8'h03, 3, 8'hA3); wr(8'h04, 4, 8'hA3);
    rd(8'h01, 3); rd(8'h02, 2); rd(8'h03, 1); rd(8'h04, 0);

    do_reset();

`ifndef WB_FIFO_TARGET_ERR_EN
    // A read held on an empty FIFO waits, then completes once a write lands.
    drive(1, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("pend_ack", i, 32'(ack_o), 32'd0);
      chk("pend_empty", i, 32'(empty_o), 32'd1);
    end
    access(1, 1, 1, 8'hA5);
    chk("a5_wr_ack", 0, 32'(ack_o), 32'd1);
    chk("a5_wr_count", 0, 32'(count_o), 32'd1);
    access(1, 1, 0, 8'h00);
    chk("a5_gap_ack", 0, 32'(ack_o), 32'd0);
    cycle();
    chk("a5_rd_ack", 0, 32'(ack_o), 32'd1);
    chk("a5_rd_dat", 0, 32'(dat_o), 32'hA5);
    chk("a5_rd_count", 0, 32'(count_o), 32'd0);
    $display("pending read sequence done: dat_o=%0h", dat_o);
    do_reset();
`endif

    foreach (vecs[i]) begin
      access(vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].dat);
      chk("vec_ack", i, 32'(ack_o), 32'(vecs[i].ack));
      chk("vec_dat", i, 32'(dat_o), 32'(vecs[i].dato));
      chk("vec_count", i, 32'(count_o), 32'(vecs[i].cnt));
      chk("vec_full", i, 32'(full_o), 32'(vecs[i].cnt == 3'd4));
      chk("vec_empty", i, 32'(empty_o), 32'(vecs[i].cnt == 3'd0));
      $display("vec %0d: cyc=%b stb=%b we=%b dat_i=%0h -> ack=%b dat_o=%0h count=%0d",
               i, vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].dat, ack_o, dat_o, count_o);
    end

    do_reset();
    acks = 0;
    drive(1, 1, 1, 8'h77);
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("b2b_ack", i, 32'(ack_o), 32'(i % 2 == 0));
      if (ack_o) acks++;
    end
    drive(0, 0, 0, 8'h00);
    chk("b2b_pulses", 0, 32'(acks), 32'd4);
    chk("b2b_count", 0, 32'(count_o), 32'd4);
    chk("b2b_full", 0, 32'(full_o), 32'd1);
    $display("back-to-back: %0d acks, count=%0d", acks, count_o);

    do_reset();
    access(1, 1, 1, 8'h5A); access(0, 0, 0, 8'h00);
    access(1, 1, 0, 8'h00); access(0, 0, 0, 8'h00);
    access(1, 1, 1, 8'h6B); access(0, 0, 0, 8'h00);
    access(1, 1, 1, 8'h7C);
    chk("pre_arst_ack", 0, 32'(ack_o), 32'd1);
    chk("pre_arst_count", 0, 32'(count_o), 32'd2);
    chk("pre_arst_dat", 0, 32'(dat_o), 32'h5A);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_ack", 0, 32'(ack_o), 32'd0);
    chk("arst_count", 0, 32'(count_o), 32'd0);
    chk("arst_dat", 0, 32'(dat_o), 32'd0);
    chk("arst_empty", 0, 32'(empty_o), 32'd1);
    $display("async reset mid-ack: ack=%b count=%0d dat_o=%0h", ack_o, count_o, dat_o);
    drive(0, 0, 0, 8'h00);
    cycle();
    rst_ni = 1'b1;

`ifdef WB_FIFO_TARGET_ERR_EN
    do_reset();
    access(1, 1, 0, 8'h00);
    chk("err_rd_err", 0, 32'(err_o), 32'd1);
    chk("err_rd_ack", 0, 32'(ack_o), 32'd0);
    chk("err_rd_count", 0, 32'(count_o), 32'd0);
    access(0, 0, 0, 8'h00);
    chk("err_rd_end", 0, 32'(err_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      access(1, 1, 1, DW'(8'hC0 + i));
      access(0, 0, 0, 8'h00);
    end
    access(1, 1, 1, 8'hEE);
    chk("err_wr_err", 0, 32'(err_o), 32'd1);
    chk("err_wr_ack", 0, 32'(ack_o), 32'd0);
    chk("err_wr_count", 0, 32'(count_o), 32'd4);
    access(0, 0, 0, 8'h00);
    chk("err_wr_end", 0, 32'(err_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      access(1, 1, 0, 8'h00);
      chk("err_drain_ack", i, 32'(ack_o), 32'd1);
      chk("err_drain_dat", i, 32'(dat_o), 32'(8'hC0 + i));
      access(0, 0, 0, 8'h00);
    end
    chk("err_drain_empty", 0, 32'(empty_o), 32'd1);
    $display("error termination sequence done");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
